// File: rtl/motor_seq_pkg.sv
// motor_seq_pkg: FSM state type and width helpers shared by motor_seq_n and btn_debounce
package motor_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DEAD, PAUSE} state_t;
  localparam int PASS_W = 16;
  function automatic int clog2_safe(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  function automatic int div_min1(input int a, input int b);
    return (a / b < 1) ? 1 : a / b;
  endfunction
  function automatic int db_cycles(input int f_clk_hz, input int db_ms);
    return div_min1(db_ms * f_clk_hz, 1000);
  endfunction
endpackage

// File: rtl/motor_seq_n_btn_debounce.sv
// btn_debounce: 2-FF sync, polarity fold, debounce counter, one-cycle rising-edge pulse
// Ports: clk, rst (async, active-high), pin (raw button), pulse (press event, 1 cycle)
module btn_debounce
  import motor_seq_pkg::*;
#(
  parameter int DB_CYC = 2,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic pulse
);
  localparam int CW = clog2_safe(DB_CYC);
  logic [1:0] sync;
  logic stable, stable_q;
  logic [CW-1:0] cnt;
  // sync holds the pressed level (active-high), so a cleared register means "released"
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync     <= '0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
      pulse    <= 1'b0;
    end else begin
      sync     <= {sync[0], pin ^ ACTIVE_LOW};
      cnt      <= (sync[1] == stable || cnt == CW'(DB_CYC - 1)) ? '0 : cnt + 1'b1;
      if (sync[1] != stable && cnt == CW'(DB_CYC - 1)) stable <= sync[1];
      stable_q <= stable;
      pulse    <= stable & ~stable_q;
    end
endmodule

// File: rtl/motor_seq_n.sv
// motor_seq_n: N-channel round-robin motor sequencer with per-channel seconds, pause, loop and test speed
// Ports: clk, rst (async, active-high); start_i/stop_i/pause_i raw buttons; test_i, loop_i levels;
//   dur_i per-channel seconds; motor_o one-hot enables; chan_o, secs_left_o, busy_o, paused_o,
//   pass_cnt_o (completed passes), done_o (single-pass completion pulse).
// Define MOTOR_SEQ_DEADTIME_EN to insert DEAD_CYC all-off cycles between channels.
module motor_seq_n
  import motor_seq_pkg::*;
#(
  parameter int F_CLK_HZ = 25_000_000,
  parameter int N_MOTORS = 4,
  parameter int SECS_W = 8,
  parameter int TEST_DIV = 10,
  parameter int DB_MS = 5,
  parameter int BTN_ACTIVE_LOW = 1,
  parameter int DEAD_CYC = 25_000,
  localparam int CW = clog2_safe(N_MOTORS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic                       stop_i,
  input  logic                       pause_i,
  input  logic                       test_i,
  input  logic                       loop_i,
  input  logic [N_MOTORS*SECS_W-1:0] dur_i,
  output logic [N_MOTORS-1:0]        motor_o,
  output logic [CW-1:0]              chan_o,
  output logic [SECS_W-1:0]          secs_left_o,
  output logic                       busy_o,
  output logic                       paused_o,
  output logic [PASS_W-1:0]          pass_cnt_o,
  output logic                       done_o
);
  localparam int PW = clog2_safe(F_CLK_HZ + 1);
  localparam logic [PW-1:0] P_FULL = PW'(F_CLK_HZ);
  localparam logic [PW-1:0] P_TEST = PW'(div_min1(F_CLK_HZ, TEST_DIV));
  localparam logic [CW-1:0] LAST = CW'(N_MOTORS - 1);
  localparam logic [N_MOTORS-1:0] ONE = 1;
  localparam int DB_CYC = db_cycles(F_CLK_HZ, DB_MS);
  state_t state_q, state_n, resume_q, resume_n;
  logic start_p, stop_p, pause_p, tick, chan_end, done_n;
  logic [1:0] test_sync, loop_sync;
  logic [CW-1:0] chan_q, chan_n, nxt;
  logic [SECS_W-1:0] secs_q, secs_n;
  logic [PW-1:0] pre_q, pre_n;
  logic [PASS_W-1:0] pass_q, pass_n;
  logic [N_MOTORS-1:0] motor_n;
`ifdef MOTOR_SEQ_DEADTIME_EN
  localparam int DW = clog2_safe(DEAD_CYC);
  logic [DW-1:0] dead_q, dead_n;
`endif
  btn_debounce #(.DB_CYC(DB_CYC), .ACTIVE_LOW(BTN_ACTIVE_LOW != 0)) u_start (.clk(clk), .rst(rst), .pin(start_i), .pulse(start_p));
  btn_debounce #(.DB_CYC(DB_CYC), .ACTIVE_LOW(BTN_ACTIVE_LOW != 0)) u_stop  (.clk(clk), .rst(rst), .pin(stop_i),  .pulse(stop_p));
  btn_debounce #(.DB_CYC(DB_CYC), .ACTIVE_LOW(BTN_ACTIVE_LOW != 0)) u_pause (.clk(clk), .rst(rst), .pin(pause_i), .pulse(pause_p));
  function automatic logic [SECS_W-1:0] dur_of(input logic [CW-1:0] c);
    return dur_i[int'(c) * SECS_W +: SECS_W];
  endfunction
  // ">=" lets a live switch to the shorter test period tick at once instead of wrapping
  assign tick     = pre_q >= (test_sync[1] ? P_TEST : P_FULL) - 1'b1;
  // a zero-second channel ends in its first cycle, which is the one-cycle skip
  assign chan_end = secs_q == '0 || (tick && secs_q == SECS_W'(1));
  assign nxt      = (chan_q == LAST) ? '0 : chan_q + 1'b1;
  always_comb begin
    state_n  = state_q;
    resume_n = resume_q;
    chan_n   = chan_q;
    secs_n   = secs_q;
    pre_n    = pre_q;
    pass_n   = pass_q;
    done_n   = 1'b0;
`ifdef MOTOR_SEQ_DEADTIME_EN
    dead_n   = dead_q;
`endif
    case (state_q)
      IDLE: if (start_p && !stop_p && !pause_p && |dur_i) begin
        state_n = RUN;
        chan_n  = '0;
        secs_n  = dur_of('0);
        pre_n   = '0;
      end
      RUN: if (chan_end) begin
        pass_n = (chan_q == LAST) ? pass_q + 1'b1 : pass_q;
        if (chan_q == LAST && !loop_sync[1]) begin
          state_n = IDLE;
          done_n  = 1'b1;
          chan_n  = '0;
          secs_n  = '0;
          pre_n   = '0;
        end else begin
`ifdef MOTOR_SEQ_DEADTIME_EN
          state_n = DEAD;
          dead_n  = '0;
          chan_n  = nxt;
          secs_n  = '0;
          pre_n   = '0;
`else
          chan_n  = nxt;
          secs_n  = dur_of(nxt);
          pre_n   = '0;
`endif
        end
      end else begin
        secs_n = tick ? secs_q - 1'b1 : secs_q;
        pre_n  = tick ? '0 : pre_q + 1'b1;
      end
`ifdef MOTOR_SEQ_DEADTIME_EN
      DEAD: if (dead_q == DW'(DEAD_CYC - 1)) begin
        state_n = RUN;
        secs_n  = dur_of(chan_q);
        pre_n   = '0;
      end else dead_n = dead_q + 1'b1;
`endif
      PAUSE: if (pause_p || start_p) state_n = resume_q;
      default: ;
    endcase
    // the cycle a pause lands in still counts as on-time, so the normal advance
    // above is kept and only the destination is parked behind PAUSE
    if (stop_p && state_q != IDLE) begin
      state_n = IDLE;
      chan_n  = '0;
      secs_n  = '0;
      pre_n   = '0;
      pass_n  = pass_q;
      done_n  = 1'b0;
    end else if (pause_p && state_q != IDLE && state_q != PAUSE && state_n != IDLE) begin
      resume_n = state_n;
      state_n  = PAUSE;
    end
    motor_n = (state_n == RUN && secs_n != '0) ? ONE << chan_n : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      resume_q  <= IDLE;
      chan_q    <= '0;
      secs_q    <= '0;
      pre_q     <= '0;
      pass_q    <= '0;
      done_o    <= 1'b0;
      motor_o   <= '0;
      test_sync <= '0;
      loop_sync <= '0;
`ifdef MOTOR_SEQ_DEADTIME_EN
      dead_q    <= '0;
`endif
    end else begin
      resume_q  <= resume_n;
      chan_q    <= chan_n;
      secs_q    <= secs_n;
      pre_q     <= pre_n;
      pass_q    <= pass_n;
      done_o    <= done_n;
      motor_o   <= motor_n;
      test_sync <= {test_sync[0], test_i};
      loop_sync <= {loop_sync[0], loop_i};
`ifdef MOTOR_SEQ_DEADTIME_EN
      dead_q    <= dead_n;
`endif
    end
  assign chan_o      = chan_q;
  assign secs_left_o = secs_q;
  assign pass_cnt_o  = pass_q;
  assign busy_o      = state_q != IDLE;
  assign paused_o    = state_q == PAUSE;
endmodule

// File: tb/tb_motor_seq_n.sv
// tb_motor_seq_n: directed self-checking bench for motor_seq_n (F_CLK_HZ=1000, DB_MS=2, N_MOTORS=3)
module tb_motor_seq_n;
  localparam int N = 3;
  localparam int SW = 8;
`ifdef MOTOR_SEQ_DEADTIME_EN
  localparam int SKIP_GAP = 101;
`else
  localparam int SKIP_GAP = 1;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic start_i = 1'b1, stop_i = 1'b1, pause_i = 1'b1, test_i = 1'b0, loop_i = 1'b0;
  logic [N*SW-1:0] dur_i = '0;
  logic [N-1:0] motor_o;
  logic [1:0] chan_o;
  logic [SW-1:0] secs_left_o;
  logic busy_o, paused_o, done_o;
  logic [15:0] pass_cnt_o;
  int n_chk = 0, n_fail = 0;
  int first_chan, first_secs;
  motor_seq_n #(.F_CLK_HZ(1000), .N_MOTORS(N), .SECS_W(SW), .TEST_DIV(10), .DB_MS(2),
                .BTN_ACTIVE_LOW(1), .DEAD_CYC(50)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i), .pause_i(pause_i),
    .test_i(test_i), .loop_i(loop_i), .dur_i(dur_i), .motor_o(motor_o), .chan_o(chan_o),
    .secs_left_o(secs_left_o), .busy_o(busy_o), .paused_o(paused_o),
    .pass_cnt_o(pass_cnt_o), .done_o(done_o));
  always #5 clk = ~clk;
  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tap(input int b);
    if (b == 0) start_i = 1'b0;
    if (b == 1) pause_i = 1'b0;
    if (b == 2) stop_i = 1'b0;
    repeat (10) @(negedge clk);
    if (b == 0) start_i = 1'b1;
    if (b == 1) pause_i = 1'b1;
    if (b == 2) stop_i = 1'b1;
  endtask
  task automatic seg(input string tag, input logic [N-1:0] val, input int len);
    int t = 0;
    int n = 0;
    while (motor_o !== val && t < 8000) begin
      t++;
      @(negedge clk);
    end
    first_chan = chan_o;
    first_secs = secs_left_o;
    while (motor_o === val && n < len + 5) begin
      n++;
      @(negedge clk);
    end
    check(tag, n, len);
  endtask
  task automatic wait_motor(input string tag, input logic [N-1:0] val);
    int t = 0;
    while (motor_o !== val && t < 8000) begin
      t++;
      @(negedge clk);
    end
    check(tag, motor_o, val);
  endtask
  task automatic wait_idle(input string tag);
    int t = 0;
    while (busy_o !== 1'b0 && t < 100) begin
      t++;
      @(negedge clk);
    end
    check(tag, busy_o, 0);
  endtask
  initial begin
    int on, bad, seen;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_motor", motor_o, 0);
    check("rst_chan", chan_o, 0);
    check("rst_secs", secs_left_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_paused", paused_o, 0);
    check("rst_pass", pass_cnt_o, 0);
    check("rst_done", done_o, 0);
    // single pass, dur = {2,1,3}
    dur_i = {8'd3, 8'd1, 8'd2};
    loop_i = 1'b0;
    repeat (3) @(negedge clk);
    fork tap(0); join_none
    seg("t1_ch0_len", 3'b001, 2000);
    check("t1_ch0_chan", first_chan, 0);
    check("t1_ch0_secs", first_secs, 2);
`ifdef MOTOR_SEQ_DEADTIME_EN
    seg("t1_gap01", 3'b000, 50);
`endif
    seg("t1_ch1_len", 3'b010, 1000);
    check("t1_ch1_chan", first_chan, 1);
`ifdef MOTOR_SEQ_DEADTIME_EN
    seg("t1_gap12", 3'b000, 50);
`endif
    seg("t1_ch2_len", 3'b100, 3000);
    check("t1_ch2_secs", first_secs, 3);
    check("t1_done", done_o, 1);
    check("t1_pass", pass_cnt_o, 1);
    check("t1_busy", busy_o, 0);
    @(negedge clk);
    check("t1_done_pulse", done_o, 0);
    // loop with a zero-second channel skipped
    dur_i = {8'd1, 8'd0, 8'd1};
    loop_i = 1'b1;
    repeat (5) @(negedge clk);
    fork tap(0); join_none
    seg("t2_ch0_a", 3'b001, 1000);
    seg("t2_skip_a", 3'b000, SKIP_GAP);
    seg("t2_ch2_a", 3'b100, 1000);
    check("t2_pass_a", pass_cnt_o, 2);
    seg("t2_ch0_b", 3'b001, 1000);
    seg("t2_skip_b", 3'b000, SKIP_GAP);
    seg("t2_ch2_b", 3'b100, 1000);
    check("t2_pass_b", pass_cnt_o, 3);
    check("t2_busy_loop", busy_o, 1);
    fork tap(2); join_none
    wait_idle("t2_stop_idle");
    check("t2_stop_motor", motor_o, 0);
    check("t2_stop_pass", pass_cnt_o, 3);
    // test speed: 100-cycle second
    test_i = 1'b1;
    loop_i = 1'b0;
    dur_i = {8'd2, 8'd2, 8'd2};
    repeat (15) @(negedge clk);
    fork tap(0); join_none
    seg("t3_ch0", 3'b001, 200);
    seg("t3_ch1", 3'b010, 200);
    seg("t3_ch2", 3'b100, 200);
    check("t3_done", done_o, 1);
    check("t3_pass", pass_cnt_o, 4);
    // pause 300 cycles into channel 0, hold ~500 cycles, resume
    test_i = 1'b0;
    dur_i = {8'd2, 8'd1, 8'd2};
    repeat (5) @(negedge clk);
    fork tap(0); join_none
    wait_motor("t4_start", 3'b001);
    on = 0;
    bad = 0;
    seen = 0;
    for (int i = 0; i < 10000 && motor_o !== 3'b010; i++) begin
      if (motor_o === 3'b001) on++;
      if (paused_o === 1'b1) seen++;
      if (i >= 350 && i < 800 && (motor_o !== 3'b000 || paused_o !== 1'b1)) bad++;
      if (i == 300 || i == 800) fork tap(1); join_none
      @(negedge clk);
    end
    check("t4_on_cycles", on, 2000);
    check("t4_hold_off", bad, 0);
    check("t4_paused_seen", seen > 400, 1);
    fork tap(2); join_none
    wait_idle("t4_stop_idle");
    check("t4_pass_hold", pass_cnt_o, 4);
    // stop and pause pressed together during channel 2: stop wins
    dur_i = {8'd1, 8'd1, 8'd1};
    loop_i = 1'b1;
    repeat (15) @(negedge clk);
    fork tap(0); join_none
    wait_motor("t5_reach_ch2", 3'b100);
    repeat (50) @(negedge clk);
    fork tap(2); tap(1); join_none
    repeat (20) @(negedge clk);
    check("t5_busy", busy_o, 0);
    check("t5_paused", paused_o, 0);
    check("t5_motor", motor_o, 0);
    check("t5_pass", pass_cnt_o, 4);
    check("t5_chan", chan_o, 0);
    // all-zero durations: start ignored
    dur_i = '0;
    repeat (5) @(negedge clk);
    fork tap(0); join_none
    repeat (30) @(negedge clk);
    check("t6_zero_busy", busy_o, 0);
    check("t6_zero_motor", motor_o, 0);
    dur_i = {8'd1, 8'd1, 8'd1};
    repeat (5) @(negedge clk);
`ifdef MOTOR_SEQ_DEADTIME_EN
    fork tap(0); join_none
    seg("t7_ch0", 3'b001, 1000);
    seg("t7_gap01", 3'b000, 50);
    seg("t7_ch1", 3'b010, 1000);
    seg("t7_gap12", 3'b000, 50);
    seg("t7_ch2", 3'b100, 1000);
    seg("t7_gap_wrap", 3'b000, 50);
    check("t7_wrap_ch0", motor_o, 3'b001);
`endif
    // asynchronous reset mid-run
    fork tap(0); join_none
    wait_motor("t8_running", 3'b001);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t8_rst_motor", motor_o, 0);
    check("t8_rst_busy", busy_o, 0);
    check("t8_rst_pass", pass_cnt_o, 0);
    check("t8_rst_chan", chan_o, 0);
    check("t8_rst_secs", secs_left_o, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("t8_post_busy", busy_o, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
